systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
Job sequencer for the 3x3 systolic multiplier array. It latches two 3x3 operand matrices on `start`, then runs one job:
- clears the array accumulators;
- feeds A columns and B rows in lockstep for 3 cycles (the array applies its own skew);
- waits for the pipeline to drain;
- captures the 9 accumulator outputs;
- streams them out row-major over a valid/ready port.

It sits between the host/testbench and the array instance.

Parameters:
DW, 2, operand element width (bits)
CW, 5, accumulator/result width (bits); must satisfy CW >= 2*DW + 1
DRAIN_CYC, 4, cycles of zero-feed after the last operand; equals 2*(3-1)

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  job request; sampled only in IDLE
a_mat  in  9*DW  A packed; A[i][t] = a_mat[DW*(3*i+t) +: DW]
b_mat  in  9*DW  B packed; B[t][j] = b_mat[DW*(3*t+j) +: DW]
busy  out  1  high from the start acceptance edge until the done edge
arr_clr  out  1  drives array reset
arr_a1, arr_a2, arr_a3  out  DW each  array row inputs
arr_b1, arr_b2, arr_b3  out  DW each  array column inputs
arr_c  in  9*CW  array results; C[i][j] = arr_c[CW*(3*i+j) +: CW]
out_valid  out  1  result word valid
out_ready  in  1  consumer ready
out_data  out  CW  result C[idx]
out_idx  out  4  row-major index 0..8
out_last  out  1  high when out_idx == 8
done  out  1  one-cycle pulse after word 8 is accepted

Behaviour:
- Interface: one clock, `clk`; reset is synchronous and active-high on `reset`.
- Reset values:
  - State IDLE.
  - `arr_clr` = 1.
  - All `arr_a*` / `arr_b*` = 0.
  - `busy`, `out_valid`, `out_last`, `done` = 0.
  - `out_data` = 0, `out_idx` = 0.
- Outputs are registered.
- Reset at any point, including mid-job, aborts the job immediately. No partial results are emitted.
- States and transitions:
  - IDLE: `arr_clr` = 0. On `start` = 1, latch `a_mat` and `b_mat`, set `busy`, go to CLEAR.
  - CLEAR: 1 cycle. `arr_clr` = 1, operand outputs 0. Go to FEED with t = 0.
  - FEED: 3 cycles, t = 0..2. Drive `arr_a(i+1)` = A[i][t] and `arr_b(j+1)` = B[t][j]. Go to DRAIN after t = 2.
  - DRAIN: DRAIN_CYC cycles with all operand outputs 0. Go to CAPTURE.
  - CAPTURE: 1 cycle. Latch all of `arr_c` into a 9-entry result buffer. Go to OUT with idx = 0.
  - OUT: `out_valid` = 1, `out_data` = buf[idx]. On `out_valid` && `out_ready`:
    - if idx < 8, increment idx;
    - if idx == 8, pulse `done`, clear `busy` and `out_valid`, go to IDLE.
- Timing (start sampled at edge E0):
  - CLEAR after E0.
  - FEED after E1..E3.
  - DRAIN after E4..E7.
  - CAPTURE after E8.
  - First `out_valid` after E9.
  - With `out_ready` held high, word k is accepted at edge E(10+k), and `done` is high in the cycle after E18.
- Boundary conditions:
  - Backpressure: when `out_ready` = 0, `out_data`, `out_idx`, `out_last` hold.
  - `start` while `busy` is ignored; no queuing.
  - `start` held high is re-sampled in IDLE, so a new job begins on the edge after `done`.
  - Arithmetic is not computed here. Results pass through unmodified at CW bits; the array wraps mod 2^CW.

Optional Feature:
Macro: SYS_CTRL_ACCUM_EN.
- Defined: adds input port `accum` (1 bit), sampled with `start`. If `accum` = 1, the CLEAR state is skipped (IDLE goes directly to FEED), so results accumulate onto the previous job. All timing is one cycle earlier; first `out_valid` appears after E8.
- Not defined: there is no `accum` port and every job clears the array.

Decomposition:
Package `sys_pkg` holds:
- the DW/CW defaults and the N=3 constant;
- a state enum (IDLE, CLEAR, FEED, DRAIN, CAPTURE, OUT);
- the index helper constants for packing.

No sub-module; the FEED mux and result buffer stay inline.

Test Plan:
1. Identity: A = [[1,2,3],[0,1,2],[3,3,1]], B = I, `out_ready` = 1 -> `out_data` sequence 1,2,3,0,1,2,3,3,1; first `out_valid` after E9; `done` after E18.
2. Max values: A and B all 3 -> all nine words = 27. Then A all 1, B all 2 -> all = 6. This checks that CLEAR wipes the previous job.
3. Backpressure: hold `out_ready` = 0 for 3 cycles while `out_idx` = 4 -> `out_data` = C[4] stable and `out_idx` stays 4; the stream then resumes with no word lost or duplicated.
4. Reset asserted in FEED t = 1 -> next cycle `arr_clr` = 1, operand outputs 0, `busy` = 0, `out_valid` = 0. A fresh job afterwards returns correct results.
5. `start` pulsed during DRAIN -> ignored, with exactly 9 words and 1 `done`. `start` held high continuously -> back-to-back jobs, with the second CLEAR in the cycle after `done`.
6. SYS_CTRL_ACCUM_EN: A, B all 1, job 1 with `accum` = 0, then job 2 with `accum` = 1 -> job 2 outputs all = 6 and first `out_valid` after E8.

Source files
------------

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared constants, state encoding and packing helpers for the 3x3 systolic job sequencer.
package sys_pkg;

   localparam int N         = 3;
   localparam int NUM_ELEM  = N * N;
   localparam int LAST_IDX  = NUM_ELEM - 1;
   localparam int DW_DEF    = 2;
   localparam int CW_DEF    = 5;
   localparam int DRAIN_DEF = 2 * (N - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      CAPTURE,
      OUT
   } state_e;

   // Row-major element position inside a packed 3x3 matrix.
   function automatic int elem_idx(input int row, input int col);
      return N * row + col;
   endfunction

endpackage

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the 3x3 systolic array: clear, feed, drain, capture, stream results.
// Optional SYS_CTRL_ACCUM_EN adds an `accum` input that skips CLEAR so results build on the last job.
module systolic_seq_ctrl
   import sys_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int CW        = CW_DEF,
   parameter int DRAIN_CYC = DRAIN_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
`ifdef SYS_CTRL_ACCUM_EN
   input  logic                   accum,
`endif
   input  logic [NUM_ELEM*DW-1:0] a_mat,
   input  logic [NUM_ELEM*DW-1:0] b_mat,
   output logic                   busy,
   output logic                   arr_clr,
   output logic [DW-1:0]          arr_a1,
   output logic [DW-1:0]          arr_a2,
   output logic [DW-1:0]          arr_a3,
   output logic [DW-1:0]          arr_b1,
   output logic [DW-1:0]          arr_b2,
   output logic [DW-1:0]          arr_b3,
   input  logic [NUM_ELEM*CW-1:0] arr_c,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CW-1:0]          out_data,
   output logic [3:0]             out_idx,
   output logic                   out_last,
   output logic                   done
);

   localparam int CNT_W = $clog2(DRAIN_CYC + N);
   typedef logic [CNT_W-1:0] cnt_t;

   state_e                 state_q, state_d;
   cnt_t                   cnt_q, cnt_d;
   logic [NUM_ELEM*DW-1:0] a_q, a_d;
   logic [NUM_ELEM*DW-1:0] b_q, b_d;
   logic                   busy_q, busy_d;
   logic                   clr_q, clr_d;
   logic                   valid_q, valid_d;
   logic                   last_q, last_d;
   logic                   done_q, done_d;
   logic [CW-1:0]          data_q, data_d;
   logic [3:0]             idx_q, idx_d;
   logic [DW-1:0]          arr_a_q [N];
   logic [DW-1:0]          arr_a_d [N];
   logic [DW-1:0]          arr_b_q [N];
   logic [DW-1:0]          arr_b_d [N];
   logic [CW-1:0]          res_q [NUM_ELEM];
   logic [CW-1:0]          c_elem [NUM_ELEM];

   logic                   accum_req;
   logic                   feed_en;
   logic [1:0]             feed_t;
   logic [NUM_ELEM*DW-1:0] feed_a_src;
   logic [NUM_ELEM*DW-1:0] feed_b_src;

`ifdef SYS_CTRL_ACCUM_EN
   assign accum_req = accum;
`else
   assign accum_req = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ELEM; gi++) begin : g_unpack
         assign c_elem[gi] = arr_c[CW*gi +: CW];
      end
      // Column t of A goes to the rows, row t of B to the columns; the array skews internally.
      for (gi = 0; gi < N; gi++) begin : g_feed
         assign arr_a_d[gi] = feed_en ? feed_a_src[DW*elem_idx(gi, int'(feed_t)) +: DW] : '0;
         assign arr_b_d[gi] = feed_en ? feed_b_src[DW*elem_idx(int'(feed_t), gi) +: DW] : '0;
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      busy_d     = busy_q;
      clr_d      = 1'b0;
      valid_d    = valid_q;
      data_d     = data_q;
      idx_d      = idx_q;
      last_d     = last_q;
      done_d     = 1'b0;
      feed_en    = 1'b0;
      feed_t     = 2'd0;
      feed_a_src = a_q;
      feed_b_src = b_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d    = a_mat;
               b_d    = b_mat;
               busy_d = 1'b1;
               if (accum_req) begin
                  // Operands are not latched yet, so the first column comes straight from the ports.
                  state_d    = FEED;
                  cnt_d      = '0;
                  feed_en    = 1'b1;
                  feed_a_src = a_mat;
                  feed_b_src = b_mat;
               end else begin
                  state_d = CLEAR;
                  clr_d   = 1'b1;
               end
            end
         end
         CLEAR: begin
            state_d = FEED;
            cnt_d   = '0;
            feed_en = 1'b1;
         end
         FEED: begin
            if (cnt_q == cnt_t'(N - 1)) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               feed_en = 1'b1;
               feed_t  = 2'(cnt_q + 1'b1);
            end
         end
         DRAIN: begin
            if (cnt_q == cnt_t'(DRAIN_CYC - 1)) begin
               state_d = CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CAPTURE: begin
            state_d = OUT;
            valid_d = 1'b1;
            idx_d   = 4'd0;
            data_d  = c_elem[0];
            last_d  = 1'b0;
         end
         OUT: begin
            if (valid_q && out_ready) begin
               if (idx_q == 4'(LAST_IDX)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  valid_d = 1'b0;
                  idx_d   = 4'd0;
                  data_d  = '0;
                  last_d  = 1'b0;
               end else begin
                  idx_d  = idx_q + 4'd1;
                  data_d = res_q[int'(idx_q) + 1];
                  last_d = (idx_q == 4'(LAST_IDX - 1));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         clr_q   <= 1'b1;
         valid_q <= 1'b0;
         data_q  <= '0;
         idx_q   <= 4'd0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int k = 0; k < N; k++) begin
            arr_a_q[k] <= '0;
            arr_b_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         clr_q   <= clr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         done_q  <= done_d;
         arr_a_q <= arr_a_d;
         arr_b_q <= arr_b_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_ELEM; k++) res_q[k] <= '0;
      end else if (state_q == CAPTURE) begin
         for (int k = 0; k < NUM_ELEM; k++) res_q[k] <= c_elem[k];
      end
   end

   assign busy      = busy_q;
   assign arr_clr   = clr_q;
   assign arr_a1    = arr_a_q[0];
   assign arr_a2    = arr_a_q[1];
   assign arr_a3    = arr_a_q[2];
   assign arr_b1    = arr_b_q[0];
   assign arr_b2    = arr_b_q[1];
   assign arr_b3    = arr_b_q[2];
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_idx   = idx_q;
   assign out_last  = last_q;
   assign done      = done_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a behavioural outer-product accumulator standing in for the array.
module tb_systolic_seq_ctrl;

   localparam int DW = 2;
   localparam int CW = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             out_ready = 1'b1;
`ifdef SYS_CTRL_ACCUM_EN
   logic             accum = 1'b0;
`endif
   logic [9*DW-1:0]  a_mat = '0;
   logic [9*DW-1:0]  b_mat = '0;
   logic             busy, arr_clr, out_valid, out_last, done;
   logic [DW-1:0]    arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3;
   logic [9*CW-1:0]  arr_c;
   logic [CW-1:0]    out_data;
   logic [3:0]       out_idx;

   int nchk = 0;
   int nerr = 0;
   int cyc = 0;
   int t0 = 0;
   int done_cnt = 0;
   int exp_w [9];

   logic [CW-1:0] acc [9];
   logic [DW-1:0] a_v [3];
   logic [DW-1:0] b_v [3];

   systolic_seq_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
`ifdef SYS_CTRL_ACCUM_EN
      .accum     (accum),
`endif
      .a_mat     (a_mat),
      .b_mat     (b_mat),
      .busy      (busy),
      .arr_clr   (arr_clr),
      .arr_a1    (arr_a1),
      .arr_a2    (arr_a2),
      .arr_a3    (arr_a3),
      .arr_b1    (arr_b1),
      .arr_b2    (arr_b2),
      .arr_b3    (arr_b3),
      .arr_c     (arr_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   // Array stand-in: C += a (outer) b each cycle, wrapping at CW bits.
   always_comb begin
      a_v[0] = arr_a1; a_v[1] = arr_a2; a_v[2] = arr_a3;
      b_v[0] = arr_b1; b_v[1] = arr_b2; b_v[2] = arr_b3;
   end

   always @(posedge clk) begin
      if (arr_clr === 1'b1) begin
         for (int k = 0; k < 9; k++) acc[k] <= '0;
      end else begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               acc[3*i+j] <= acc[3*i+j] + CW'(int'(a_v[i]) * int'(b_v[j]));
      end
   end

   always_comb begin
      arr_c = '0;
      for (int k = 0; k < 9; k++) arr_c[CW*k +: CW] = acc[k];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9*DW-1:0] pack9(input int m [9]);
      logic [9*DW-1:0] r;
      r = '0;
      for (int k = 0; k < 9; k++) r[DW*k +: DW] = DW'(m[k]);
      return r;
   endfunction

   function automatic logic [9*DW-1:0] fill9(input int v);
      logic [9*DW-1:0] r;
      r = '0;
      for (int k = 0; k < 9; k++) r[DW*k +: DW] = DW'(v);
      return r;
   endfunction

   task automatic set_exp_all(input int v);
      for (int k = 0; k < 9; k++) exp_w[k] = v;
   endtask

   task automatic start_job(input logic [9*DW-1:0] a, input logic [9*DW-1:0] b, input bit hold);
      a_mat = a;
      b_mat = b;
      start = 1'b1;
      step();
      t0 = cyc;
      if (!hold) start = 1'b0;
   endtask

   // Streams the nine words against exp_w, optionally stalling out_ready at one index.
   task automatic collect(input int lat, input int stall_at, input int stall_len, input string tag);
      int w;
      for (int k = 0; k < 9; k++) begin
         w = 0;
         while (out_valid !== 1'b1 && w < 30) begin
            step();
            w++;
         end
         if (k == 0) begin
            nchk++;
            if (cyc - t0 != lat) begin
               nerr++;
               $display("FAIL %s first_valid: edge %0d, required edge %0d", tag, cyc - t0, lat);
            end
         end
         nchk++;
         if (out_valid !== 1'b1 || out_idx !== 4'(k) || out_data !== CW'(exp_w[k]) || out_last !== (k == 8)) begin
            nerr++;
            $display("FAIL %s word%0d: valid=%b idx=%0d data=%0d last=%b, required valid=1 idx=%0d data=%0d last=%b",
                     tag, k, out_valid, out_idx, out_data, out_last, k, exp_w[k], k == 8);
         end
         if (k == stall_at) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               step();
               nchk++;
               if (out_valid !== 1'b1 || out_idx !== 4'(k) || out_data !== CW'(exp_w[k])) begin
                  nerr++;
                  $display("FAIL %s stall%0d: valid=%b idx=%0d data=%0d, required valid=1 idx=%0d data=%0d",
                           tag, s, out_valid, out_idx, out_data, k, exp_w[k]);
               end
            end
            out_ready = 1'b1;
         end
         step();
      end
      nchk++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL %s done: done=%b busy=%b valid=%b, required done=1 busy=0 valid=0", tag, done, busy, out_valid);
      end
      nchk++;
      if (cyc - t0 != lat + 9 + stall_len) begin
         nerr++;
         $display("FAIL %s done_edge: edge %0d, required edge %0d", tag, cyc - t0, lat + 9 + stall_len);
      end
      $display("job %s: 9 words streamed, done at edge %0d", tag, cyc - t0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      nchk++;
      if (arr_clr !== 1'b1 || {arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3} !== '0 || busy !== 1'b0 ||
          out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || out_data !== '0 || out_idx !== 4'd0) begin
         nerr++;
         $display("FAIL reset_state: clr=%b ops=%h busy=%b valid=%b last=%b done=%b data=%0d idx=%0d, required clr=1 rest 0",
                  arr_clr, {arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3}, busy, out_valid, out_last, done, out_data, out_idx);
      end
      reset = 1'b0;
      step();
      nchk++;
      if (arr_clr !== 1'b0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL idle_state: clr=%b busy=%b, required clr=0 busy=0", arr_clr, busy);
      end
      $display("reset: checked");
   endtask

   task automatic test_identity();
      int am [9];
      int bm [9];
      am = '{1, 2, 3, 0, 1, 2, 3, 3, 1};
      bm = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      exp_w = '{1, 2, 3, 0, 1, 2, 3, 3, 1};
      start_job(pack9(am), pack9(bm), 1'b0);
      nchk++;
      if (busy !== 1'b1 || arr_clr !== 1'b1) begin
         nerr++;
         $display("FAIL clear_state: busy=%b clr=%b, required busy=1 clr=1", busy, arr_clr);
      end
      step();
      nchk++;
      if ({arr_a1, arr_a2, arr_a3} !== {2'd1, 2'd0, 2'd3} || {arr_b1, arr_b2, arr_b3} !== {2'd1, 2'd0, 2'd0} || arr_clr !== 1'b0) begin
         nerr++;
         $display("FAIL feed_t0: a=%0d,%0d,%0d b=%0d,%0d,%0d clr=%b, required a=1,0,3 b=1,0,0 clr=0",
                  arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3, arr_clr);
      end
      collect(9, -1, 0, "identity");
      step();
      nchk++;
      if (done !== 1'b0) begin
         nerr++;
         $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
      end
   endtask

   task automatic test_max_values();
      set_exp_all(27);
      start_job(fill9(3), fill9(3), 1'b0);
      collect(9, -1, 0, "max3x3");
      step();
      set_exp_all(6);
      start_job(fill9(1), fill9(2), 1'b0);
      collect(9, -1, 0, "ones_twos");
      step();
   endtask

   task automatic test_backpressure();
      int am [9];
      int bm [9];
      am = '{2, 1, 0, 1, 3, 2, 0, 2, 1};
      bm = '{1, 2, 3, 3, 0, 1, 2, 1, 1};
      exp_w = '{5, 4, 7, 14, 4, 8, 8, 1, 3};
      start_job(pack9(am), pack9(bm), 1'b0);
      collect(9, 4, 3, "backpressure");
      step();
   endtask

   task automatic test_reset_mid_job();
      int am [9];
      int bm [9];
      int seen;
      am = '{1, 2, 3, 0, 1, 2, 3, 3, 1};
      bm = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      start_job(pack9(am), pack9(bm), 1'b0);
      step();
      step();
      nchk++;
      if ({arr_a1, arr_a2, arr_a3} !== {2'd2, 2'd1, 2'd3} || {arr_b1, arr_b2, arr_b3} !== {2'd0, 2'd1, 2'd0}) begin
         nerr++;
         $display("FAIL feed_t1: a=%0d,%0d,%0d b=%0d,%0d,%0d, required a=2,1,3 b=0,1,0",
                  arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3);
      end
      reset = 1'b1;
      step();
      nchk++;
      if (arr_clr !== 1'b1 || {arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3} !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL abort: clr=%b ops=%h busy=%b valid=%b, required clr=1 ops=0 busy=0 valid=0",
                  arr_clr, {arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3}, busy, out_valid);
      end
      reset = 1'b0;
      seen = 0;
      repeat (14) begin
         step();
         if (out_valid === 1'b1 || done === 1'b1) seen++;
      end
      nchk++;
      if (seen != 0) begin
         nerr++;
         $display("FAIL no_partial: %0d cycles with valid/done after abort, required 0", seen);
      end
      am = '{2, 1, 0, 1, 3, 2, 0, 2, 1};
      bm = '{1, 2, 3, 3, 0, 1, 2, 1, 1};
      exp_w = '{5, 4, 7, 14, 4, 8, 8, 1, 3};
      start_job(pack9(am), pack9(bm), 1'b0);
      collect(9, -1, 0, "after_abort");
      step();
   endtask

   task automatic test_start_ignored();
      int am [9];
      int bm [9];
      int d0;
      int seen;
      am = '{1, 2, 3, 0, 1, 2, 3, 3, 1};
      bm = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      exp_w = '{1, 2, 3, 0, 1, 2, 3, 3, 1};
      d0 = done_cnt;
      start_job(pack9(am), pack9(bm), 1'b0);
      repeat (5) step();
      a_mat = fill9(3);
      b_mat = fill9(3);
      start = 1'b1;
      step();
      start = 1'b0;
      collect(9, -1, 0, "start_in_drain");
      seen = 0;
      repeat (12) begin
         step();
         if (out_valid === 1'b1 || busy === 1'b1) seen++;
      end
      nchk++;
      if (done_cnt - d0 != 1 || seen != 0) begin
         nerr++;
         $display("FAIL no_queue: done pulses=%0d extra busy/valid cycles=%0d, required 1 and 0", done_cnt - d0, seen);
      end
   endtask

   task automatic test_back_to_back();
      int am [9];
      int bm [9];
      am = '{1, 2, 3, 0, 1, 2, 3, 3, 1};
      bm = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      exp_w = '{1, 2, 3, 0, 1, 2, 3, 3, 1};
      start_job(pack9(am), pack9(bm), 1'b1);
      collect(9, -1, 0, "held_start_1");
      a_mat = fill9(1);
      b_mat = fill9(2);
      step();
      t0 = cyc;
      start = 1'b0;
      nchk++;
      if (arr_clr !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL restart_clear: clr=%b busy=%b valid=%b after done, required clr=1 busy=1 valid=0", arr_clr, busy, out_valid);
      end
      set_exp_all(6);
      collect(9, -1, 0, "held_start_2");
      step();
   endtask

`ifdef SYS_CTRL_ACCUM_EN
   task automatic test_accum();
      accum = 1'b0;
      set_exp_all(3);
      start_job(fill9(1), fill9(1), 1'b0);
      collect(9, -1, 0, "accum_job1");
      step();
      accum = 1'b1;
      start_job(fill9(1), fill9(1), 1'b0);
      accum = 1'b0;
      nchk++;
      if (arr_clr !== 1'b0 || arr_a1 !== 2'd1 || busy !== 1'b1) begin
         nerr++;
         $display("FAIL accum_skip_clear: clr=%b a1=%0d busy=%b, required clr=0 a1=1 busy=1", arr_clr, arr_a1, busy);
      end
      set_exp_all(6);
      collect(8, -1, 0, "accum_job2");
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_identity();
      test_max_values();
      test_backpressure();
      test_reset_mid_job();
      test_start_ignored();
      test_back_to_back();
`ifdef SYS_CTRL_ACCUM_EN
      test_accum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end

endmodule
